// File: rtl/ffm_emit_arbiter_if.sv
// ffm_emit_arbiter_if: per-channel frame-former streams in, one shared M_AXIS stream out
// master: arbiter side (takes S_AXIS_* and M_AXIS_tready, drives S_AXIS_tready and M_AXIS_*)
// slave: environment side (frame formers plus downstream sink)
interface ffm_emit_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0] S_AXIS_tvalid;
  logic [NUM_CH-1:0] S_AXIS_tlast;
  logic [NUM_CH*DATA_W-1:0] S_AXIS_tdata;
  logic [NUM_CH-1:0] S_AXIS_tready;
  logic M_AXIS_tready;
  logic M_AXIS_tvalid;
  logic M_AXIS_tlast;
  logic [DATA_W-1:0] M_AXIS_tdata;
  modport master (
    input  S_AXIS_tvalid, S_AXIS_tlast, S_AXIS_tdata, M_AXIS_tready,
    output S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata
  );
  modport slave (
    output S_AXIS_tvalid, S_AXIS_tlast, S_AXIS_tdata, M_AXIS_tready,
    input  S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata
  );
endinterface

// File: rtl/ffm_emit_arbiter.sv
// ffm_emit_arbiter: frame-granular round-robin scheduler sharing one M_AXIS among NUM_CH frame formers
// ACLK/ARESET: clock, sync active-high reset; Delay/TimerInit/GapInit: fill threshold, flush timer, inter-frame gap
// FFSTail: per-channel fill levels; Grant/GrantValid: granted channel, high while sending; bus: stream interface
module ffm_emit_arbiter #(
  parameter int NUM_CH = 4,
  parameter int MAX_INTERNAL_SPACE = 64,
  parameter int DATA_W = 32,
  parameter int TIMER_W = 9,
  localparam int W = $clog2(MAX_INTERNAL_SPACE) + 1,
  localparam int GW = $clog2(NUM_CH)
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic [W-1:0] Delay,
  input  logic [TIMER_W-1:0] TimerInit,
  input  logic [TIMER_W-1:0] GapInit,
  input  logic [NUM_CH*W-1:0] FFSTail,
  output logic [GW-1:0] Grant,
  output logic GrantValid,
  ffm_emit_arbiter_if.master bus
);
  typedef enum logic [1:0] {GAP, ARB, SEND} state_t;
  state_t r_state;
  logic [GW-1:0] r_grant, r_rr;
  logic r_gv;
  logic [TIMER_W-1:0] r_tmr [NUM_CH];
  logic [TIMER_W-1:0] r_gap;
  logic [W-1:0] w_thr;
  logic [NUM_CH-1:0] w_elig;
  logic w_found, w_send, w_xfer, w_last;
  logic [GW-1:0] w_pick, w_next_rr;
  assign w_thr = (Delay == '0) ? '0 : Delay - 1'b1;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_elig[i] = bus.S_AXIS_tvalid[i] & ((FFSTail[i*W +: W] >= w_thr) | (r_tmr[i] == '0));
  end
  // scan from the highest offset down so the channel closest to r_rr wins
  always_comb begin
    int j;
    j = 0;
    w_found = 1'b0;
    w_pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = (int'(r_rr) + k) % NUM_CH;
      if (w_elig[j[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick = j[GW-1:0];
      end
    end
  end
  assign w_next_rr = (w_pick == GW'(NUM_CH - 1)) ? '0 : w_pick + 1'b1;
  // reset gates the pass-through so a partial frame is cut off in the reset cycle itself
  assign w_send = (r_state == SEND) && !ARESET;
  assign w_last = bus.S_AXIS_tlast[r_grant];
  assign bus.M_AXIS_tvalid = w_send & bus.S_AXIS_tvalid[r_grant];
  assign bus.M_AXIS_tlast = w_send & w_last;
  assign bus.M_AXIS_tdata = w_send ? bus.S_AXIS_tdata[r_grant*DATA_W +: DATA_W] : '0;
  assign bus.S_AXIS_tready = w_send ? (NUM_CH'(bus.M_AXIS_tready) << r_grant) : '0;
  assign w_xfer = bus.M_AXIS_tvalid & bus.M_AXIS_tready;
  assign Grant = r_grant;
  assign GrantValid = r_gv;
  // the flush timer only runs while a channel holds data and is not being served
  always_ff @(posedge ACLK)
    for (int i = 0; i < NUM_CH; i++)
      if (ARESET || !bus.S_AXIS_tvalid[i] || (r_state == SEND && r_grant == GW'(i))) r_tmr[i] <= TimerInit;
      else if (r_tmr[i] != '0) r_tmr[i] <= r_tmr[i] - 1'b1;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= ARB;
      r_grant <= '0;
      r_rr <= '0;
      r_gv <= 1'b0;
      r_gap <= '0;
    end else if (r_state == ARB) begin
      if (w_found) begin
        r_state <= SEND;
        r_grant <= w_pick;
        r_rr <= w_next_rr;
        r_gv <= 1'b1;
      end
    end else if (r_state == SEND) begin
      if (w_xfer && w_last) begin
        r_state <= (GapInit == '0) ? ARB : GAP;
        r_gap <= GapInit;
        r_gv <= 1'b0;
      end
    end else begin
      r_gap <= r_gap - 1'b1;
      if (r_gap == TIMER_W'(1)) r_state <= ARB;
    end
  end
endmodule
